// File: rtl/amp_pkg.sv
// Shared types and constants for the thermometer amplitude quantizer.
// The thresholds are ascending, so every quantizer output is thermometer-shaped.
package amp_pkg;

  localparam int AMP_LEVELS = 16;

  typedef logic [AMP_LEVELS-1:0] amp_code_t;

  localparam logic [7:0] AMP_THRESH [AMP_LEVELS] = '{
    8'd1,   8'd3,   8'd7,   8'd13,  8'd21,  8'd31,  8'd43,  8'd57,
    8'd75,  8'd91,  8'd111, 8'd133, 8'd157, 8'd183, 8'd201, 8'd241
  };

endpackage

// File: rtl/amp_quant.sv
// Combinational 8-bit amplitude to 16-level thermometer code.
// Bit k is set when the sample is strictly greater than threshold k.
module amp_quant
  import amp_pkg::*;
(
  input  logic [7:0] sample,
  output amp_code_t  code
);

  always_comb begin
    code = '0;
    for (int k = 0; k < AMP_LEVELS; k++) begin
      code[k] = (sample > AMP_THRESH[k]);
    end
  end

endmodule

// File: rtl/amp_rr_sched.sv
// Round-robin scheduler sharing one thermometer quantizer among NREQ requesters,
// with a single registered output stage and valid/ready backpressure.
module amp_rr_sched
  import amp_pkg::*;
#(
  parameter int NREQ = 4,
  parameter int IDW  = $clog2(NREQ)
) (
  input  logic              clock,
  input  logic              rst_n,
  input  logic [NREQ-1:0]   req_valid,
  input  logic [NREQ*8-1:0] req_data,
  output logic [NREQ-1:0]   req_ready,
  output logic              out_valid,
  input  logic              out_ready,
  output amp_code_t         out_ap,
  output logic [IDW-1:0]    out_id,
  output logic              busy
);

  logic            out_valid_q, out_valid_d;
  amp_code_t       out_ap_q,    out_ap_d;
  logic [IDW-1:0]  out_id_q,    out_id_d;
  logic [IDW-1:0]  last_id_q,   last_id_d;

  logic [NREQ-1:0] grant;
  logic            gnt_any;
  logic [IDW-1:0]  gnt_id;
  logic [IDW-1:0]  idx;
  logic [7:0]      sel_data;
  amp_code_t       quant_code;
  logic            can_accept;
  logic            accept;

  // Search upward from last_id+1 with wrap; the first valid requester wins.
  always_comb begin
    grant    = '0;
    gnt_any  = 1'b0;
    gnt_id   = '0;
    sel_data = '0;
    idx      = last_id_q;
    for (int n = 0; n < NREQ; n++) begin
      idx = (idx == IDW'(NREQ - 1)) ? '0 : idx + IDW'(1);
      if (!gnt_any && req_valid[idx]) begin
        gnt_any     = 1'b1;
        grant[idx]  = 1'b1;
        gnt_id      = idx;
        sel_data    = req_data[{idx, 3'b000} +: 8];
      end
    end
  end

  amp_quant u_quant (
    .sample (sel_data),
    .code   (quant_code)
  );

  assign can_accept = ~out_valid_q | out_ready;
  assign accept     = gnt_any & can_accept;
  assign req_ready  = grant & {NREQ{can_accept}};

  // A new accept takes priority over draining, so drain+load share one edge.
  always_comb begin
    out_valid_d = out_valid_q;
    out_ap_d    = out_ap_q;
    out_id_d    = out_id_q;
    last_id_d   = last_id_q;
    if (accept) begin
      out_valid_d = 1'b1;
      out_ap_d    = quant_code;
      out_id_d    = gnt_id;
      last_id_d   = gnt_id;
    end else if (out_valid_q && out_ready) begin
      out_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clock or negedge rst_n) begin
    if (!rst_n) begin
      out_valid_q <= 1'b0;
      out_ap_q    <= '0;
      out_id_q    <= '0;
      last_id_q   <= IDW'(NREQ - 1);
    end else begin
      out_valid_q <= out_valid_d;
      out_ap_q    <= out_ap_d;
      out_id_q    <= out_id_d;
      last_id_q   <= last_id_d;
    end
  end

  assign out_valid = out_valid_q;
  assign out_ap    = out_ap_q;
  assign out_id    = out_id_q;
  assign busy      = (|req_valid) | out_valid_q;

endmodule
